ldpc_decode_ctrl: RTL
=====================

Name: ldpc_decode_ctrl

Overview:
- Sequencer for one stochastic LDPC decode over a bank of NBITS saturating up/down decision counters.
- Clears the counter bank, then runs the stochastic stream for a warm-up period.
- Then polls the parity-check result at a fixed interval, terminating early on convergence or at a cycle cap.
- Latches the hard decisions and reports them via a START/BUSY/DONE handshake to the host-side codeword buffer.

Parameters:
- NBITS, 16, codeword length (number of decision counters / sign bits).
- CWIDTH, 10, width of the decode-cycle counter and CYCLES output.
- WARMUP, 4, enabled cycles before any syndrome check.
- CHECK_INT, 4, enabled cycles between syndrome checks.
- MAXCYC, 20, maximum enabled cycles per decode.
- Legality: WARMUP ≥ 0; CHECK_INT ≥ 1; WARMUP < MAXCYC < 2^CWIDTH.

Ports:
- CLK  in  1  clock; all logic on posedge.
- INIT  in  1  reset.
- START  in  1  decode request; accepted only in IDLE.
- SYND_OK  in  1  all parity checks satisfied by DEC_IN this cycle.
- DEC_IN  in  NBITS  sign bits from counter bank, 1 = negative.
- CNT_CLR  out  1  synchronous clear to counter bank.
- CNT_EN  out  1  counter bank / stochastic stream update enable.
- BUSY  out  1  high from START acceptance until DONE cycle inclusive.
- DONE  out  1  one-cycle completion pulse.
- CONVERGED  out  1  last decode met parity.
- DEC_OUT  out  NBITS  latched hard decisions of last decode.
- CYCLES  out  CWIDTH  enabled cycles used by last decode.

Behaviour:
- One clock CLK. Reset INIT is synchronous, active-high.
- While INIT is high: state = IDLE, all outputs 0, internal counters 0.
- INIT mid-decode: abort; no DONE; results cleared to 0.
- All outputs are registered or decoded from registered state only; none is combinational from inputs.
- States and transitions:
  - IDLE: BUSY=0. START=1 → CLEAR.
  - CLEAR: exactly one cycle; CNT_CLR=1, BUSY=1. cyc←0, ic←0. → WARM, or → RUN if WARMUP=0.
  - WARM: CNT_EN=1; cyc increments each cycle. At cyc=WARMUP-1 → RUN. No syndrome sampling.
  - RUN: CNT_EN=1; cyc increments; ic counts 0..CHECK_INT-1 and wraps. Check point is ic=CHECK_INT-1.
    - Check point with SYND_OK=1 → FINISH, converged.
    - Otherwise, if cyc=MAXCYC-1 → FINISH, not converged.
    - Both conditions in the same cycle: convergence wins.
    - SYND_OK outside check points is ignored.
  - FINISH: one cycle; DONE=1, BUSY=1, CNT_EN=0 → IDLE.
- Result latching, on the edge leaving RUN:
  - DEC_OUT←DEC_IN.
  - CONVERGED←decision.
  - CYCLES←cyc+1.
- Results hold until the next FINISH or INIT; they remain valid during a subsequent run.
- Check points fall at cyc = WARMUP + k·CHECK_INT - 1, k ≥ 1.
- Latency:
  - START edge → CNT_CLR in next cycle.
  - First CNT_EN follows one cycle after CNT_CLR.
  - DONE occurs one cycle after the last CNT_EN cycle.
- START while BUSY: ignored, not queued.
- START held high through FINISH: a new decode starts only after one IDLE cycle.
- cyc never wraps, because MAXCYC < 2^CWIDTH.

Decomposition:
- Shared package ldpc_ctrl_pkg holds:
  - state encoding localparams: IDLE, CLEAR, WARM, RUN, FINISH;
  - default WARMUP, CHECK_INT, MAXCYC constants, shared with the counter-bank and syndrome blocks.
- One sub-module, ldpc_check_timer:
  - holds the cyc/ic counters with clear and enable;
  - outputs at_warm_end, at_check, at_max flags.
- The FSM and result registers stay in the top.

Test Plan:
1. INIT high 2 cycles, random START/SYND_OK → BUSY, DONE, CNT_EN, CNT_CLR, CONVERGED, CYCLES, DEC_OUT all 0; state IDLE.
2. START pulse, SYND_OK held 1, DEC_IN=16'hA5C3 → CNT_CLR 1 cycle, CNT_EN 8 cycles, DONE next cycle; CONVERGED=1, CYCLES=8, DEC_OUT=16'hA5C3.
3. START, SYND_OK held 0 → CNT_EN 20 cycles, then DONE; CONVERGED=0, CYCLES=20.
4. SYND_OK pulsed only at cyc=9 → ignored. Pulsed at cyc=11 → DONE after that cycle; CONVERGED=1, CYCLES=12.
5. SYND_OK=1 only at cyc=19 (check point coinciding with MAXCYC-1) → CONVERGED=1, CYCLES=20.
6. INIT asserted at cyc=6 of RUN → IDLE next cycle, no DONE, results 0. Then START during BUSY of a fresh run → run length unchanged, no second DONE.

Source files
------------

// File: rtl/ldpc_ctrl_pkg.sv
// ldpc_ctrl_pkg: shared definitions for the stochastic LDPC decode sequencer.
// Holds the controller state encoding and the default schedule constants that
// the counter-bank and syndrome blocks size themselves against.
package ldpc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    WARM   = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam int DEF_NBITS     = 16;
  localparam int DEF_CWIDTH    = 10;
  localparam int DEF_WARMUP    = 4;
  localparam int DEF_CHECK_INT = 4;
  localparam int DEF_MAXCYC    = 20;

endpackage

// File: rtl/ldpc_check_timer.sv
// ldpc_check_timer: decode-cycle counter (cyc) and syndrome-check interval
// counter (ic) for one decode.
//   clk_i, init_i      : clock, synchronous active-high reset
//   clr_i              : zero both counters (CLEAR state)
//   cyc_en_i           : advance cyc (WARM and RUN)
//   ic_en_i            : advance ic, wrapping at CHECK_INT-1 (RUN only)
//   cyc_o              : current enabled-cycle index
//   at_warm_end_o      : cyc is the last warm-up cycle
//   at_check_o         : ic is at a check point
//   at_max_o           : cyc is the last allowed cycle
module ldpc_check_timer
  import ldpc_ctrl_pkg::*;
#(
  parameter int CWIDTH    = DEF_CWIDTH,
  parameter int WARMUP    = DEF_WARMUP,
  parameter int CHECK_INT = DEF_CHECK_INT,
  parameter int MAXCYC    = DEF_MAXCYC
) (
  input  logic              clk_i,
  input  logic              init_i,
  input  logic              clr_i,
  input  logic              cyc_en_i,
  input  logic              ic_en_i,
  output logic [CWIDTH-1:0] cyc_o,
  output logic              at_warm_end_o,
  output logic              at_check_o,
  output logic              at_max_o
);

  localparam int IW = (CHECK_INT > 1) ? $clog2(CHECK_INT) : 1;

  // WARMUP=0 never visits WARM, so its compare value is irrelevant there.
  localparam logic [CWIDTH-1:0] WARM_LAST = CWIDTH'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CWIDTH-1:0] MAX_LAST  = CWIDTH'(MAXCYC - 1);
  localparam logic [IW-1:0]     IC_LAST   = IW'(CHECK_INT - 1);

  logic [CWIDTH-1:0] cyc_q;
  logic [IW-1:0]     ic_q;

  always_ff @(posedge clk_i) begin
    if (init_i || clr_i) begin
      cyc_q <= '0;
      ic_q  <= '0;
    end else begin
      if (cyc_en_i) cyc_q <= cyc_q + CWIDTH'(1);
      if (ic_en_i)  ic_q  <= (ic_q == IC_LAST) ? '0 : ic_q + IW'(1);
    end
  end

  assign cyc_o         = cyc_q;
  assign at_warm_end_o = (WARMUP > 0) && (cyc_q == WARM_LAST);
  assign at_check_o    = (ic_q == IC_LAST);
  assign at_max_o      = (cyc_q == MAX_LAST);

endmodule

// File: rtl/ldpc_decode_ctrl.sv
// ldpc_decode_ctrl: sequencer for one stochastic LDPC decode.
// Clears the counter bank, runs a warm-up, then polls SYND_OK every CHECK_INT
// enabled cycles until convergence or MAXCYC, latching the hard decisions.
//   CLK, INIT : clock, synchronous active-high reset
//   START     : decode request (honoured only in IDLE)
//   SYND_OK   : parity satisfied by DEC_IN this cycle
//   DEC_IN    : sign bits from counter bank
//   CNT_CLR   : counter-bank clear (one cycle)
//   CNT_EN    : counter-bank / stochastic stream enable
//   BUSY/DONE : handshake to the codeword buffer
//   CONVERGED, DEC_OUT, CYCLES : results of the last completed decode
module ldpc_decode_ctrl
  import ldpc_ctrl_pkg::*;
#(
  parameter int NBITS     = DEF_NBITS,
  parameter int CWIDTH    = DEF_CWIDTH,
  parameter int WARMUP    = DEF_WARMUP,
  parameter int CHECK_INT = DEF_CHECK_INT,
  parameter int MAXCYC    = DEF_MAXCYC
) (
  input  logic              CLK,
  input  logic              INIT,
  input  logic              START,
  input  logic              SYND_OK,
  input  logic [NBITS-1:0]  DEC_IN,
  output logic              CNT_CLR,
  output logic              CNT_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              CONVERGED,
  output logic [NBITS-1:0]  DEC_OUT,
  output logic [CWIDTH-1:0] CYCLES
);

  state_e            state_q, state_d;
  logic              cnt_clr_q, cnt_en_q, busy_q, done_q, conv_q;
  logic [NBITS-1:0]  dec_q;
  logic [CWIDTH-1:0] cycles_q;

  logic [CWIDTH-1:0] cyc;
  logic              at_warm_end, at_check, at_max;
  logic              leave_run, conv_hit;

  ldpc_check_timer #(
    .CWIDTH(CWIDTH), .WARMUP(WARMUP), .CHECK_INT(CHECK_INT), .MAXCYC(MAXCYC)
  ) u_timer (
    .clk_i         (CLK),
    .init_i        (INIT),
    .clr_i         (state_q == CLEAR),
    .cyc_en_i      ((state_q == WARM) || (state_q == RUN)),
    .ic_en_i       (state_q == RUN),
    .cyc_o         (cyc),
    .at_warm_end_o (at_warm_end),
    .at_check_o    (at_check),
    .at_max_o      (at_max)
  );

  always_comb begin
    state_d   = state_q;
    leave_run = 1'b0;
    conv_hit  = 1'b0;
    unique case (state_q)
      IDLE:   if (START) state_d = CLEAR;
      CLEAR:  state_d = (WARMUP == 0) ? RUN : WARM;
      WARM:   if (at_warm_end) state_d = RUN;
      RUN: begin
        // A passing check on the last allowed cycle still counts as converged.
        if (at_check && SYND_OK) begin
          leave_run = 1'b1;
          conv_hit  = 1'b1;
        end else if (at_max) begin
          leave_run = 1'b1;
        end
        if (leave_run) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up
  // with state_q in the cycle they describe.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q   <= IDLE;
      cnt_clr_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      dec_q     <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= (state_d == CLEAR);
      cnt_en_q  <= (state_d == WARM) || (state_d == RUN);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == FINISH);
      if (leave_run) begin
        conv_q   <= conv_hit;
        dec_q    <= DEC_IN;
        cycles_q <= cyc + CWIDTH'(1);
      end
    end
  end

  assign CNT_CLR   = cnt_clr_q;
  assign CNT_EN    = cnt_en_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CONVERGED = conv_q;
  assign DEC_OUT   = dec_q;
  assign CYCLES    = cycles_q;

endmodule
